csr_file: RTL and testbench

Machine-mode RISC-V control/status register file for the core. It decodes a 12-bit CSR address for combinational reads and registered writes, enforcing per-register legal values. It also generates the trap redirect (ecall/ebreak entry, `mret` return) consumed by the fetch/PC logic.

---
 rtl/csr_file_pkg.sv | 43 ++++
 rtl/csr_file_if.sv | 28 ++
 rtl/csr_file.sv | 90 +++++++++
 tb/tb_csr_file.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// Shared CSR constants, cause codes and the mcause legality check.
package csr_file_pkg;

  localparam int unsigned CSR_XLEN = 32;
  localparam int unsigned ADDR_W   = 12;

  localparam logic [ADDR_W-1:0] CSR_MVENDORID = 12'hF11;
  localparam logic [ADDR_W-1:0] CSR_MARCHID   = 12'hF12;
  localparam logic [ADDR_W-1:0] CSR_MIMPID    = 12'hF13;
  localparam logic [ADDR_W-1:0] CSR_MHARTID   = 12'hF14;
  localparam logic [ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [ADDR_W-1:0] CSR_MISA      = 12'h301;
  localparam logic [ADDR_W-1:0] CSR_MIE       = 12'h304;
  localparam logic [ADDR_W-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [ADDR_W-1:0] CSR_MEPC      = 12'h341;
  localparam logic [ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [ADDR_W-1:0] CSR_MTVAL     = 12'h343;
  localparam logic [ADDR_W-1:0] CSR_MIP       = 12'h344;

  localparam logic [CSR_XLEN-1:0] MISA_VALUE = 32'h4000_0100;

  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

  // True when value may be stored in mcause (interrupt or exception code).
  function automatic logic mcause_legal(input logic [CSR_XLEN-1:0] value);
    logic ok;
    ok = 1'b0;
    if (value[CSR_XLEN-2:4] == '0) begin
      if (value[CSR_XLEN-1]) begin
        case (value[3:0])
          4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd11: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end else begin
        ok = (value[3:0] != 4'd10) && (value[3:0] != 4'd14);
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR access and trap-redirect signals between the core and the CSR file.
interface csr_file_if #(
  parameter int unsigned XLEN = 32
);
  import csr_file_pkg::*;

  logic              csr_w;
  logic [ADDR_W-1:0] csr_addr;
  logic [XLEN-1:0]   csr_din;
  logic [XLEN-1:0]   csr_dout;
  logic              exc_ecall;
  logic              exc_break;
  logic              is_mret;
  logic [XLEN-1:0]   pc_now;
  logic              trap_pc;
  logic [XLEN-1:0]   pc_trap;

  modport master (
    output csr_w, csr_addr, csr_din, exc_ecall, exc_break, is_mret, pc_now,
    input  csr_dout, trap_pc, pc_trap
  );

  modport slave (
    input  csr_w, csr_addr, csr_din, exc_ecall, exc_break, is_mret, pc_now,
    output csr_dout, trap_pc, pc_trap
  );

endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: registered writes with legal-value masking,
// combinational reads, and ecall/ebreak/mret PC redirect.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int unsigned XLEN = CSR_XLEN
) (
  input  logic           clk,
  input  logic           rstl,
  csr_file_if.slave      bus
);

  logic            mstatus_mie;
  logic [2:0]      mie_bits;   // bits 11, 7, 3
  logic [2:0]      mip_bits;   // bits 11, 7, 3
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic            trap_entry;

  assign trap_entry = bus.exc_ecall | bus.exc_break;

  // CSR state: trap entry takes precedence and suppresses a same-cycle write.
  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      mstatus_mie <= 1'b0;
      mie_bits    <= '0;
      mip_bits    <= '0;
      mtvec       <= '0;
      mscratch    <= '0;
      mepc        <= '0;
      mcause      <= '0;
      mtval       <= '0;
    end else if (trap_entry) begin
      mepc        <= bus.pc_now;
      mcause      <= XLEN'(bus.exc_ecall ? CAUSE_ECALL_M : CAUSE_BREAKPOINT);
      mtval       <= '0;
      mstatus_mie <= 1'b0;
    end else if (bus.csr_w) begin
      case (bus.csr_addr)
        CSR_MSTATUS:  mstatus_mie <= bus.csr_din[3];
        CSR_MIE:      mie_bits    <= {bus.csr_din[11], bus.csr_din[7], bus.csr_din[3]};
        CSR_MIP:      mip_bits    <= {bus.csr_din[11], bus.csr_din[7], bus.csr_din[3]};
        CSR_MTVEC:    mtvec       <= {bus.csr_din[XLEN-1:2],
                                      bus.csr_din[1] ? 2'b00 : bus.csr_din[1:0]};
        CSR_MSCRATCH: mscratch    <= bus.csr_din;
        CSR_MTVAL:    mtval       <= bus.csr_din;
        CSR_MCAUSE: begin
          if (mcause_legal(bus.csr_din)) mcause <= bus.csr_din;
        end
        default: ;
      endcase
    end
  end

  // Read mux: constants and masked views of the stored state.
  always_comb begin
    bus.csr_dout = '0;
    case (bus.csr_addr)
      CSR_MSTATUS:  bus.csr_dout = XLEN'({2'b11, 7'b0, mstatus_mie, 3'b0});
      CSR_MISA:     bus.csr_dout = XLEN'(MISA_VALUE);
      CSR_MIE:      bus.csr_dout = XLEN'({mie_bits[2], 3'b0, mie_bits[1], 3'b0,
                                          mie_bits[0], 3'b0});
      CSR_MIP:      bus.csr_dout = XLEN'({mip_bits[2], 3'b0, mip_bits[1], 3'b0,
                                          mip_bits[0], 3'b0});
      CSR_MTVEC:    bus.csr_dout = mtvec;
      CSR_MSCRATCH: bus.csr_dout = mscratch;
      CSR_MEPC:     bus.csr_dout = mepc;
      CSR_MCAUSE:   bus.csr_dout = mcause;
      CSR_MTVAL:    bus.csr_dout = mtval;
      default:      bus.csr_dout = '0;
    endcase
  end

  // Redirect: exceptions go to the mtvec base, mret returns past mepc.
  always_comb begin
    bus.trap_pc = 1'b0;
    bus.pc_trap = '0;
    if (trap_entry) begin
      bus.trap_pc = 1'b1;
      bus.pc_trap = {mtvec[XLEN-1:2], 2'b00};
    end else if (bus.is_mret) begin
      bus.trap_pc = 1'b1;
      bus.pc_trap = mepc + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: write/readback table plus trap sequences.
module tb_csr_file;
  import csr_file_pkg::*;

  localparam int unsigned NV = 19;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rstl;
  int   n_cmp;
  int   n_bad;
  vec_t vecs [NV];

  csr_file_if #(.XLEN(32)) bus ();

  csr_file #(.XLEN(32)) dut (
    .clk  (clk),
    .rstl (rstl),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    bus.csr_addr = addr;
    #1;
    check(name, bus.csr_dout, exp);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] din);
    @(negedge clk);
    bus.csr_w    = 1'b1;
    bus.csr_addr = addr;
    bus.csr_din  = din;
    @(posedge clk);
    #1;
    bus.csr_w    = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{CSR_MSTATUS,  32'hFFFF_FFFF, 32'h0000_1808};
    vecs[1]  = '{CSR_MIE,      32'hFFFF_FFFF, 32'h0000_0888};
    vecs[2]  = '{CSR_MIP,      32'hFFFF_FFFF, 32'h0000_0888};
    vecs[3]  = '{CSR_MSCRATCH, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{CSR_MTVAL,    32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5]  = '{CSR_MISA,     32'hFFFF_FFFF, 32'h4000_0100};
    vecs[6]  = '{CSR_MHARTID,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{CSR_MVENDORID,32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{CSR_MTVEC,    32'h1000_0002, 32'h1000_0000};
    vecs[9]  = '{CSR_MTVEC,    32'h1000_0001, 32'h1000_0001};
    vecs[10] = '{CSR_MCAUSE,   32'h8000_0007, 32'h8000_0007};
    vecs[11] = '{CSR_MCAUSE,   32'h0000_000A, 32'h8000_0007};
    vecs[12] = '{CSR_MCAUSE,   32'h8000_000C, 32'h8000_0007};
    vecs[13] = '{CSR_MCAUSE,   32'h0000_0002, 32'h0000_0002};
    vecs[14] = '{CSR_MCAUSE,   32'h8000_000B, 32'h8000_000B};
    vecs[15] = '{CSR_MCAUSE,   32'h0000_000E, 32'h8000_000B};
    vecs[16] = '{CSR_MSTATUS,  32'h0000_0000, 32'h0000_1800};
    vecs[17] = '{12'h7C0,      32'hFFFF_FFFF, 32'h0000_0000};
    vecs[18] = '{CSR_MEPC,     32'hFFFF_FFFF, 32'h0000_0000};

    bus.csr_w     = 1'b0;
    bus.csr_addr  = '0;
    bus.csr_din   = '0;
    bus.exc_ecall = 1'b0;
    bus.exc_break = 1'b0;
    bus.is_mret   = 1'b0;
    bus.pc_now    = '0;
    rstl = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstl = 1'b1;

    rd("reset_mcause", CSR_MCAUSE, 32'h0);
    rd("reset_mstatus", CSR_MSTATUS, 32'h0000_1800);
    check("idle_trap_pc", 32'(bus.trap_pc), 32'h0);
    check("idle_pc_trap", bus.pc_trap, 32'h0);

    for (int i = 0; i < int'(NV); i++) begin
      wr(vecs[i].addr, vecs[i].din);
      rd($sformatf("vec%0d_addr%03h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end

    // Mask fuzz on mie/mip/mstatus
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      wr(CSR_MIE, r);
      rd($sformatf("fuzz_mie%0d", i), CSR_MIE, r & 32'h0000_0888);
      wr(CSR_MIP, ~r);
      rd($sformatf("fuzz_mip%0d", i), CSR_MIP, ~r & 32'h0000_0888);
      wr(CSR_MSTATUS, r);
      rd($sformatf("fuzz_mstatus%0d", i), CSR_MSTATUS, 32'h0000_1800 | (r & 32'h8));
    end

    // Trap entry: mode 1 stored in mtvec, target drops the mode bits
    wr(CSR_MTVEC, 32'h0000_0401);
    wr(CSR_MSTATUS, 32'h0000_0008);
    wr(CSR_MTVAL, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.pc_now    = 32'h0000_1234;
    bus.exc_ecall = 1'b1;
    #1;
    check("ecall_trap_pc", 32'(bus.trap_pc), 32'h1);
    check("ecall_pc_trap", bus.pc_trap, 32'h0000_0400);
    bus.is_mret = 1'b1;
    #1;
    check("ecall_over_mret", bus.pc_trap, 32'h0000_0400);
    bus.is_mret   = 1'b0;
    bus.exc_ecall = 1'b0;
    bus.exc_break = 1'b1;
    #1;
    check("break_trap_pc", 32'(bus.trap_pc), 32'h1);
    check("break_pc_trap", bus.pc_trap, 32'h0000_0400);
    @(posedge clk);
    #1;
    bus.exc_break = 1'b0;
    rd("break_mepc", CSR_MEPC, 32'h0000_1234);
    rd("break_mcause", CSR_MCAUSE, 32'h3);
    rd("break_mstatus", CSR_MSTATUS, 32'h0000_1800);
    rd("break_mtval", CSR_MTVAL, 32'h0);
    bus.is_mret = 1'b1;
    #1;
    check("mret_trap_pc", 32'(bus.trap_pc), 32'h1);
    check("mret_pc_trap", bus.pc_trap, 32'h0000_1238);
    bus.is_mret = 1'b0;
    #1;
    check("after_mret_trap_pc", 32'(bus.trap_pc), 32'h0);
    rd("mret_no_state_change", CSR_MEPC, 32'h0000_1234);

    // Write in the same cycle as ecall+ebreak is dropped; ecall wins cause
    wr(CSR_MSCRATCH, 32'h0000_0055);
    @(negedge clk);
    bus.csr_w     = 1'b1;
    bus.csr_addr  = CSR_MSCRATCH;
    bus.csr_din   = 32'h0000_00AA;
    bus.exc_ecall = 1'b1;
    bus.exc_break = 1'b1;
    bus.pc_now    = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    bus.csr_w     = 1'b0;
    bus.exc_ecall = 1'b0;
    bus.exc_break = 1'b0;
    rd("suppressed_mscratch", CSR_MSCRATCH, 32'h0000_0055);
    rd("ecall_mepc", CSR_MEPC, 32'hFFFF_FFFC);
    rd("ecall_mcause", CSR_MCAUSE, 32'd11);
    bus.is_mret = 1'b1;
    #1;
    check("mret_wrap", bus.pc_trap, 32'h0);
    bus.is_mret = 1'b0;

    // Asynchronous reset between edges
    @(negedge clk);
    #1 rstl = 1'b0;
    #1;
    rd("async_mscratch", CSR_MSCRATCH, 32'h0);
    rd("async_mepc", CSR_MEPC, 32'h0);
    rd("async_mtvec", CSR_MTVEC, 32'h0);
    rd("async_mstatus", CSR_MSTATUS, 32'h0000_1800);
    @(negedge clk);
    rstl = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
